// File: rtl/f2f_pair_scheduler.sv
// Round-robin scheduler that shares one fixed-to-float converter among NUM_REQ requesters.
// Source IDs ride alongside in a tag FIFO; results land in a credit-protected output FIFO.
module f2f_pair_scheduler #(
  parameter int NUM_REQ            = 4,
  parameter int OUT_DEPTH          = 8,
  parameter int POS_STRUCT_WIDTH   = 48,
  parameter int FLOAT_STRUCT_WIDTH = 96,
  parameter int ID_WIDTH           = $clog2(NUM_REQ),
  parameter int CNT_WIDTH          = $clog2(OUT_DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    i_req_valid,
  input  logic [NUM_REQ*POS_STRUCT_WIDTH-1:0]   i_req_home_pos,
  input  logic [NUM_REQ*POS_STRUCT_WIDTH-1:0]   i_req_nb_pos,
  output logic [NUM_REQ-1:0]                    o_req_ready,
  output logic [POS_STRUCT_WIDTH-1:0]           o_f2f_home_pos,
  output logic [POS_STRUCT_WIDTH-1:0]           o_f2f_nb_pos,
  output logic                                  o_f2f_pair_valid,
  input  logic [FLOAT_STRUCT_WIDTH-1:0]         i_f2f_home_pos_float,
  input  logic [FLOAT_STRUCT_WIDTH-1:0]         i_f2f_nb_pos_float,
  input  logic                                  i_f2f_pair_valid,
  output logic                                  o_pair_valid,
  output logic [FLOAT_STRUCT_WIDTH-1:0]         o_home_pos_float,
  output logic [FLOAT_STRUCT_WIDTH-1:0]         o_nb_pos_float,
  output logic [ID_WIDTH-1:0]                   o_src_id,
  input  logic                                  i_pair_ready,
  output logic [CNT_WIDTH-1:0]                  o_outstanding,
  output logic                                  o_err
);

  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int EW = ID_WIDTH + 2 * FLOAT_STRUCT_WIDTH;

  logic [POS_STRUCT_WIDTH-1:0] home_arr [NUM_REQ];
  logic [POS_STRUCT_WIDTH-1:0] nb_arr   [NUM_REQ];

  logic [ID_WIDTH-1:0]         ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]        outst_q, outst_d;
  logic [POS_STRUCT_WIDTH-1:0] f2f_home_q, f2f_home_d;
  logic [POS_STRUCT_WIDTH-1:0] f2f_nb_q, f2f_nb_d;
  logic                        f2f_vld_q, f2f_vld_d;
  logic                        err_q, err_d;

  logic [ID_WIDTH-1:0]         tag_mem_q [OUT_DEPTH];
  logic [AW-1:0]               tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CNT_WIDTH-1:0]        tag_cnt_q, tag_cnt_d;
  logic [EW-1:0]               out_mem_q [OUT_DEPTH];
  logic [AW-1:0]               out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [CNT_WIDTH-1:0]        out_cnt_q, out_cnt_d;

  logic                        issue_ok_s, grant_found_s, transfer_s;
  logic [ID_WIDTH-1:0]         grant_idx_s;
  int                          scan_idx_s;
  logic [NUM_REQ-1:0]          req_ready_s;
  logic                        tag_pop_s, stray_s, out_full_s, out_pop_s, out_wr_s, out_ovf_s;
  logic [ID_WIDTH-1:0]         tag_head_s;
  logic [EW-1:0]               out_head_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(OUT_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + AW'(1);
    end
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign home_arr[g] = i_req_home_pos[g*POS_STRUCT_WIDTH +: POS_STRUCT_WIDTH];
    assign nb_arr[g]   = i_req_nb_pos[g*POS_STRUCT_WIDTH +: POS_STRUCT_WIDTH];
  end

  // Round-robin scan from ptr with wrap; grant is suppressed when credits are exhausted.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    scan_idx_s    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx_s = int'(ptr_q) + i;
      if (scan_idx_s >= NUM_REQ) begin
        scan_idx_s = scan_idx_s - NUM_REQ;
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!grant_found_s && i_req_valid[ID_WIDTH'(scan_idx_s)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = ID_WIDTH'(scan_idx_s);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    issue_ok_s = (outst_q < CNT_WIDTH'(OUT_DEPTH));
    transfer_s = grant_found_s & issue_ok_s & ~rst;
    if (transfer_s) begin
      req_ready_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // Next-state for arbiter pointer, credits, issue register and both FIFOs.
  always_comb begin
    tag_head_s = tag_mem_q[tag_rd_q];
    out_head_s = out_mem_q[out_rd_q];
    tag_pop_s  = i_f2f_pair_valid & (tag_cnt_q != '0);
    stray_s    = i_f2f_pair_valid & (tag_cnt_q == '0);
    out_full_s = (out_cnt_q == CNT_WIDTH'(OUT_DEPTH));
    out_pop_s  = (out_cnt_q != '0) & i_pair_ready;
    out_wr_s   = tag_pop_s & (~out_full_s | out_pop_s);
    out_ovf_s  = tag_pop_s & out_full_s & ~out_pop_s;
    err_d      = err_q | stray_s | out_ovf_s;

    ptr_d      = ptr_q;
    f2f_home_d = f2f_home_q;
    f2f_nb_d   = f2f_nb_q;
    f2f_vld_d  = transfer_s;
    if (transfer_s) begin
      ptr_d      = (grant_idx_s == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx_s + ID_WIDTH'(1);
      f2f_home_d = home_arr[grant_idx_s];
      f2f_nb_d   = nb_arr[grant_idx_s];
    end else begin
      ptr_d      = ptr_q;
    end

    case ({transfer_s, out_pop_s})
      2'b10:   outst_d = outst_q + CNT_WIDTH'(1);
      2'b01:   outst_d = outst_q - CNT_WIDTH'(1);
      default: outst_d = outst_q;
    endcase

    tag_wr_d = transfer_s ? ptr_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d = tag_pop_s  ? ptr_inc(tag_rd_q) : tag_rd_q;
    case ({transfer_s, tag_pop_s})
      2'b10:   tag_cnt_d = tag_cnt_q + CNT_WIDTH'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - CNT_WIDTH'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase

    out_wr_d = out_wr_s  ? ptr_inc(out_wr_q) : out_wr_q;
    out_rd_d = out_pop_s ? ptr_inc(out_rd_q) : out_rd_q;
    case ({out_wr_s, out_pop_s})
      2'b10:   out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
      2'b01:   out_cnt_d = out_cnt_q - CNT_WIDTH'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      outst_q    <= '0;
      f2f_home_q <= '0;
      f2f_nb_q   <= '0;
      f2f_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      tag_cnt_q  <= '0;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      out_cnt_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      outst_q    <= outst_d;
      f2f_home_q <= f2f_home_d;
      f2f_nb_q   <= f2f_nb_d;
      f2f_vld_q  <= f2f_vld_d;
      err_q      <= err_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_cnt_q  <= tag_cnt_d;
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  // FIFO storage; contents are qualified by the counters, so no reset is needed.
  always_ff @(posedge clk) begin
    if (transfer_s) begin
      tag_mem_q[tag_wr_q] <= grant_idx_s;
    end
    if (out_wr_s && !rst) begin
      out_mem_q[out_wr_q] <= {tag_head_s, i_f2f_home_pos_float, i_f2f_nb_pos_float};
    end
  end

  assign o_req_ready      = req_ready_s;
  assign o_f2f_home_pos   = f2f_home_q;
  assign o_f2f_nb_pos     = f2f_nb_q;
  assign o_f2f_pair_valid = f2f_vld_q;
  assign o_outstanding    = outst_q;
  assign o_err            = err_q;
  // Head fields read as zero while empty so stale storage never shows.
  assign o_pair_valid     = (out_cnt_q != '0);
  assign o_src_id         = o_pair_valid ? out_head_s[EW-1 -: ID_WIDTH] : '0;
  assign o_home_pos_float = o_pair_valid ? out_head_s[2*FLOAT_STRUCT_WIDTH-1 -: FLOAT_STRUCT_WIDTH] : '0;
  assign o_nb_pos_float   = o_pair_valid ? out_head_s[FLOAT_STRUCT_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_f2f_pair_scheduler.sv
// Scoreboard bench for f2f_pair_scheduler with a one-cycle behavioural converter stand-in.
module tb_f2f_pair_scheduler;

  localparam int NR = 4;
  localparam int PW = 48;
  localparam int FW = 96;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  i_req_valid;
  logic [NR*PW-1:0] i_req_home_pos, i_req_nb_pos;
  logic [NR-1:0]  o_req_ready;
  logic [PW-1:0]  o_f2f_home_pos, o_f2f_nb_pos;
  logic           o_f2f_pair_valid;
  logic [FW-1:0]  i_f2f_home_pos_float, i_f2f_nb_pos_float;
  logic           i_f2f_pair_valid;
  logic           o_pair_valid;
  logic [FW-1:0]  o_home_pos_float, o_nb_pos_float;
  logic [1:0]     o_src_id;
  logic           i_pair_ready;
  logic [3:0]     o_outstanding;
  logic           o_err;

  logic           cv_vld;
  logic           inj;
  logic [PW-1:0]  home_s [NR];
  logic [PW-1:0]  nb_s   [NR];

  typedef struct packed {
    logic [1:0]    id;
    logic [FW-1:0] h;
    logic [FW-1:0] n;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err    = 0;
  int n_iss    = 0;
  int n_con    = 0;
  int m_ptr    = 0;
  logic m_err  = 1'b0;

  f2f_pair_scheduler dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_home_pos(i_req_home_pos), .i_req_nb_pos(i_req_nb_pos),
    .o_req_ready(o_req_ready),
    .o_f2f_home_pos(o_f2f_home_pos), .o_f2f_nb_pos(o_f2f_nb_pos), .o_f2f_pair_valid(o_f2f_pair_valid),
    .i_f2f_home_pos_float(i_f2f_home_pos_float), .i_f2f_nb_pos_float(i_f2f_nb_pos_float),
    .i_f2f_pair_valid(i_f2f_pair_valid),
    .o_pair_valid(o_pair_valid), .o_home_pos_float(o_home_pos_float), .o_nb_pos_float(o_nb_pos_float),
    .o_src_id(o_src_id), .i_pair_ready(i_pair_ready),
    .o_outstanding(o_outstanding), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] conv_h(input logic [PW-1:0] p);
    return {p ^ 48'h5A5A_0F0F_3C3C, p + 48'd1};
  endfunction

  function automatic logic [FW-1:0] conv_n(input logic [PW-1:0] p);
    return {~p, p ^ 48'h1234_5678_9ABC};
  endfunction

  function automatic logic [PW-1:0] rand48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  // Reference arbiter: first valid requester at or after ptr, none when all credits are used.
  function automatic logic [3:0] exp_grant(input logic [3:0] v, input int p, input int outst);
    logic [3:0] g;
    g = 4'b0;
    if (outst < 8) begin
      for (int i = 0; i < NR; i++) begin
        int k;
        k = (p + i) % NR;
        if (v[k] && g == 4'b0) g = 4'b1 << k;
      end
    end
    return g;
  endfunction

  // Converter stand-in: latency 1, shares reset with the scheduler.
  always_ff @(posedge clk) begin
    if (rst) begin
      cv_vld               <= 1'b0;
      i_f2f_home_pos_float <= '0;
      i_f2f_nb_pos_float   <= '0;
    end else begin
      cv_vld               <= o_f2f_pair_valid;
      i_f2f_home_pos_float <= conv_h(o_f2f_home_pos);
      i_f2f_nb_pos_float   <= conv_n(o_f2f_nb_pos);
    end
  end
  assign i_f2f_pair_valid = cv_vld | inj;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // One clock of stimulus, plus reference-model checks of grant, credits and error flag.
  task automatic cyc(input logic [3:0] v, input logic rdy, input logic rs, input logic inj_v, input logic fix);
    logic [3:0] eg;
    @(negedge clk);
    rst = rs; i_req_valid = v; i_pair_ready = rdy; inj = inj_v;
    for (int j = 0; j < NR; j++) begin
      home_s[j] = rand48();
      nb_s[j]   = rand48();
    end
    if (fix) home_s[2] = 48'h100;
    for (int j = 0; j < NR; j++) begin
      i_req_home_pos[j*PW +: PW] = home_s[j];
      i_req_nb_pos[j*PW +: PW]   = nb_s[j];
    end
    #1;
    eg = rs ? 4'b0 : exp_grant(v, m_ptr, n_iss - n_con);
    chk("req_ready", {124'd0, o_req_ready}, {124'd0, eg});
    chk("outstanding", {124'd0, o_outstanding}, 128'(n_iss - n_con));
    chk("err", {127'd0, o_err}, {127'd0, m_err});
    if (rs) begin
      q.delete();
      n_iss = 0; n_con = 0; m_ptr = 0; m_err = 1'b0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (eg[k]) begin
          q.push_back('{id: 2'(k), h: conv_h(home_s[k]), n: conv_n(nb_s[k])});
          n_iss++;
          m_ptr = (k + 1) % NR;
        end
      end
      if (inj_v) m_err = 1'b1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (n_iss != n_con && t < 60) begin
      cyc(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      t++;
    end
    chk("drain_done", 128'(n_iss - n_con), 128'd0);
  endtask

  task automatic chk_reset();
    chk("rst_req_ready", {124'd0, o_req_ready}, 128'd0);
    chk("rst_f2f_valid", {127'd0, o_f2f_pair_valid}, 128'd0);
    chk("rst_f2f_home", {80'd0, o_f2f_home_pos}, 128'd0);
    chk("rst_f2f_nb", {80'd0, o_f2f_nb_pos}, 128'd0);
    chk("rst_pair_valid", {127'd0, o_pair_valid}, 128'd0);
    chk("rst_home_float", {32'd0, o_home_pos_float}, 128'd0);
    chk("rst_nb_float", {32'd0, o_nb_pos_float}, 128'd0);
    chk("rst_src_id", {126'd0, o_src_id}, 128'd0);
    chk("rst_outstanding", {124'd0, o_outstanding}, 128'd0);
    chk("rst_err", {127'd0, o_err}, 128'd0);
  endtask

  // Monitor: every consumed output is matched in order against the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b1 && o_pair_valid === 1'b1 && i_pair_ready === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_output: got src %0d with empty scoreboard at %0t", o_src_id, $time);
        end else begin
          e = q.pop_front();
          chk("out_src_id", {126'd0, o_src_id}, {126'd0, e.id});
          chk("out_home_float", {32'd0, o_home_pos_float}, {32'd0, e.h});
          chk("out_nb_float", {32'd0, o_nb_pos_float}, {32'd0, e.n});
        end
        n_con++;
      end
    end
  end

  initial begin
    rst = 1'b1; i_req_valid = '0; i_pair_ready = 1'b0; inj = 1'b0;
    i_req_home_pos = '0; i_req_nb_pos = '0;
    cyc(4'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(4'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_reset();

    // Single request from requester 2, latency to output.
    cyc(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("single_grant", {124'd0, o_req_ready}, {124'd0, 4'b0100});
    cyc(4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_f2f_valid", {127'd0, o_f2f_pair_valid}, 128'd1);
    chk("t1_f2f_home", {80'd0, o_f2f_home_pos}, 128'h100);
    cyc(4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_pair_valid", {127'd0, o_pair_valid}, 128'd0);
    cyc(4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_pair_valid", {127'd0, o_pair_valid}, 128'd1);
    chk("t3_src_id", {126'd0, o_src_id}, 128'd2);
    chk("t3_home_float", {32'd0, o_home_pos_float}, {32'd0, conv_h(48'h100)});
    cyc(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("single_outst_after", {124'd0, o_outstanding}, 128'd0);

    // All requesters continuously valid with ready high: rotation 0,1,2,3.
    for (int i = 0; i < 16; i++) cyc(4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Backpressure: credits cap at 8, consume frees one grant on the following cycle.
    for (int i = 0; i < 12; i++) cyc(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_outstanding", {124'd0, o_outstanding}, 128'd8);
    cyc(4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_consume_no_grant", {124'd0, o_req_ready}, 128'd0);
    cyc(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("grant_after_consume", 128'($countones(o_req_ready)), 128'd1);
    cyc(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("capped_again", {124'd0, o_req_ready}, 128'd0);
    drain();

    // Randomised traffic and backpressure.
    for (int i = 0; i < 400; i++) begin
      cyc(4'($urandom()), ($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'b0);
    end
    drain();
    cyc(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stray converter result: sticky error, nothing buffered, cleared by reset.
    cyc(4'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stray_err", {127'd0, o_err}, 128'd1);
    chk("stray_no_output", {127'd0, o_pair_valid}, 128'd0);
    cyc(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stray_no_output2", {127'd0, o_pair_valid}, 128'd0);
    cyc(4'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_reset();

    // Reset with 5 buffered and 2 in flight; pointer must restart at 0.
    for (int i = 0; i < 5; i++) cyc(4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 7; i++) cyc(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_reset();
    cyc(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_lowest", {124'd0, o_req_ready}, {124'd0, 4'b0010});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
